// File: rtl/pc_ir_unit.sv
// pc_ir_unit: program counter, instruction register and memory data register
// for the multicycle MIPS datapath. It supplies the memory address, holds the
// fetched instruction and its decode fields, and updates the PC from the
// control FSM's sequencing strobes.
module pc_ir_unit #(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = 32'h0040_0000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  PCWrite,
    input  logic                  branch,
    input  logic                  PCSrc,
    input  logic                  jump_select,
    input  logic                  IRWrite,
    input  logic                  IorD,
    input  logic                  zero,
    input  logic [DATA_WIDTH-1:0] alu_result,
    input  logic [DATA_WIDTH-1:0] alu_out,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic [DATA_WIDTH-1:0] pc,
    output logic [DATA_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] instr,
    output logic [5:0]            Op,
    output logic [5:0]            funct,
    output logic [4:0]            rs,
    output logic [4:0]            rt,
    output logic [4:0]            rd,
    output logic [DATA_WIDTH-1:0] imm_sext,
    output logic [DATA_WIDTH-1:0] mdr,
    output logic [DATA_WIDTH-1:0] instr_count,
    output logic                  pc_err
);

    logic [DATA_WIDTH-1:0] pc_reg, pc_next;
    logic [DATA_WIDTH-1:0] instr_reg, instr_next;
    logic [DATA_WIDTH-1:0] mdr_reg;
    logic [DATA_WIDTH-1:0] instr_count_reg, instr_count_next;
    logic                  pc_err_reg, pc_err_next;

    logic                  pc_en;
    logic [DATA_WIDTH-1:0] jump_target;
    logic [DATA_WIDTH-1:0] pc_target;
    logic                  pc_misaligned;

    // Next-state logic: PC target selection, alignment guard, IR and counter.
    always_comb begin
        pc_en         = PCWrite | (branch & zero);
        // The PC has already been advanced by fetch, so its top nibble is
        // the region of the instruction following the jump.
        jump_target   = {pc_reg[31:28], instr_reg[25:0], 2'b00};
        pc_target     = alu_result;
        if (PCSrc) begin
            pc_target = jump_select ? alu_out : jump_target;
        end
        pc_misaligned = (pc_target[1:0] != 2'b00);

        pc_next     = pc_reg;
        pc_err_next = pc_err_reg;
        if (pc_en) begin
            if (pc_misaligned) begin
                // A misaligned target is refused; the PC keeps its value
                // and the error is latched until reset.
                pc_err_next = 1'b1;
            end else begin
                pc_next = pc_target;
            end
        end

        instr_next       = instr_reg;
        instr_count_next = instr_count_reg;
        if (IRWrite) begin
            instr_next       = rd_data;
            instr_count_next = instr_count_reg + 1'b1;
        end
    end

    // State registers with synchronous active-low reset that overrides every strobe.
    always_ff @(posedge clk) begin
        if (!reset) begin
            pc_reg          <= RESET_PC;
            instr_reg       <= '0;
            mdr_reg         <= '0;
            instr_count_reg <= '0;
            pc_err_reg      <= 1'b0;
        end else begin
            pc_reg          <= pc_next;
            instr_reg       <= instr_next;
            mdr_reg         <= rd_data;
            instr_count_reg <= instr_count_next;
            pc_err_reg      <= pc_err_next;
        end
    end

    // Decode fields come only from the IR, so there is no path from rd_data to Op/funct.
    assign mem_addr    = IorD ? alu_out : pc_reg;
    assign pc          = pc_reg;
    assign instr       = instr_reg;
    assign mdr         = mdr_reg;
    assign instr_count = instr_count_reg;
    assign pc_err      = pc_err_reg;
    assign Op          = instr_reg[31:26];
    assign rs          = instr_reg[25:21];
    assign rt          = instr_reg[20:16];
    assign rd          = instr_reg[15:11];
    assign funct       = instr_reg[5:0];

    // Sign extension: lower half straight from the IR, upper half replicates bit 15.
    assign imm_sext[15:0] = instr_reg[15:0];
    genvar gi;
    generate
        for (gi = 16; gi < DATA_WIDTH; gi++) begin : g_sext
            assign imm_sext[gi] = instr_reg[15];
        end
    endgenerate

endmodule
